// File: rtl/sum_stream_tx.sv
// Reads DEPTH sum words from the sum RAM in address order and streams them as a
// framed, little-endian byte stream (SYNC0, SYNC1, then 5 bytes per word) over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// HDR0  | presenting SYNC0
// HDR1  | presenting SYNC1
// RD    | one-cycle sum RAM read at the current address
// CAP   | RAM data valid; loaded into the shift register
// SEND  | presenting the 5 bytes of the captured word, LSB first
// DONE  | one-cycle done pulse, busy still high
module sum_stream_tx #(
  parameter int          DEPTH  = 768,
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 40,
  parameter logic [7:0]  SYNC0  = 8'hA5,
  parameter logic [7:0]  SYNC1  = 8'h5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sum_read_addr,
  output logic              sum_read_en,
  input  logic [DATA_W-1:0] sum_ram_data_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_RD, S_CAP, S_SEND, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAST_BYTE = 3'd4;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [2:0]          idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_last_q, tx_last_d;
  logic                xfer;

  assign xfer = tx_valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR0;
          addr_d  = '0;
        end
      end
      S_HDR0: if (xfer) state_d = S_HDR1;
      S_HDR1: if (xfer) state_d = S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        shift_d = sum_ram_data_out;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_BYTE) begin
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_RD;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next-state values.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rd_en_d    = (state_d == S_RD);
    tx_valid_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_SEND);
    tx_last_d  = (state_d == S_SEND) && (addr_d == LAST_ADDR) && (idx_d == LAST_BYTE);
    tx_data_d  = 8'h00;
    case (state_d)
      S_HDR0:  tx_data_d = SYNC0;
      S_HDR1:  tx_data_d = SYNC1;
      S_SEND:  tx_data_d = shift_d[7:0];
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign sum_read_addr = addr_q;
  assign sum_read_en   = rd_en_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign tx_last       = tx_last_q;

endmodule

// File: tb/tb_sum_stream_tx.sv
// Bench for sum_stream_tx: a byte-queue frame model plus read/done monitors checked
// every cycle, with directed frames covering ordering, back-pressure, start-while-busy and reset.
module tb_sum_stream_tx;
  localparam int DEPTH = 768;
  localparam int TOTAL = 2 + 5 * DEPTH;

  logic        clk = 1'b0;
  logic        reset, start, tx_ready;
  logic        busy, done, sum_read_en, tx_valid, tx_last;
  logic [9:0]  sum_read_addr;
  logic [39:0] sum_ram_data_out;
  logic [7:0]  tx_data;

  logic [39:0] mem [0:DEPTH-1];
  int          cyc = 0;

  sum_stream_tx dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .sum_read_addr(sum_read_addr), .sum_read_en(sum_read_en),
    .sum_ram_data_out(sum_ram_data_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sum_read_en) sum_ram_data_out <= mem[sum_read_addr];

  int         checks = 0, errors = 0;
  logic [7:0] byte_q[$];
  logic [7:0] rx [0:TOTAL-1];
  int         nbytes, last_cyc, done_cyc, frames_done, rd_cnt, exp_addr, t0;
  logic       prev_en, prev_stall, zero_next;
  logic       ready_toggle, stall_on;
  int         stall_cnt;

  task check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task build_frame();
    logic [39:0] w;
    byte_q.delete();
    byte_q.push_back(8'hA5);
    byte_q.push_back(8'h5A);
    for (int k = 0; k < DEPTH; k++) begin
      w = mem[k];
      for (int b = 0; b < 5; b++) byte_q.push_back(8'((w >> (8 * b)) & 40'hFF));
    end
    nbytes = 0;
  endtask

  task compare_loop();
    forever begin
      @(negedge clk);
      if (zero_next) begin
        zero_next = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_last", tx_last, 0);
        check("rst_rden", sum_read_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_addr", sum_read_addr, 0);
      end
      if (!reset) begin
        byte_q.delete();
        zero_next  = 1'b1;
        rd_cnt     = 0;
        exp_addr   = 0;
        prev_en    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("valid_held", tx_valid, 1);
        if (tx_valid) begin
          check("byte_expected", byte_q.size() > 0, 1);
          if (byte_q.size() > 0) begin
            check("tx_data", tx_data, byte_q[0]);
            check("tx_last", tx_last, byte_q.size() == 1);
            if (tx_ready) begin
              if (nbytes < TOTAL) rx[nbytes] = tx_data;
              nbytes++;
              if (tx_last) last_cyc = cyc;
              void'(byte_q.pop_front());
            end
          end
        end else begin
          check("last_without_valid", tx_last, 0);
        end
        prev_stall = tx_valid && !tx_ready;
        check("addr_range", sum_read_addr < DEPTH, 1);
        if (sum_read_en) begin
          check("rd_single_cycle", prev_en, 0);
          check("rd_addr", sum_read_addr, exp_addr);
          exp_addr++;
          rd_cnt++;
        end
        prev_en = sum_read_en;
        if (done) begin
          check("done_all_sent", byte_q.size(), 0);
          check("done_rd_count", rd_cnt, DEPTH);
          done_cyc = cyc;
          frames_done++;
          rd_cnt   = 0;
          exp_addr = 0;
        end
      end
    end
  endtask

  // Byte 2 of word 767 is frame byte 3839.
  task ready_loop();
    forever begin
      @(posedge clk);
      #1;
      if (stall_on && nbytes == 3839 && stall_cnt < 100) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else if (ready_toggle) begin
        tx_ready = ~tx_ready;
      end else begin
        tx_ready = 1'b1;
      end
    end
  endtask

  task launch();
    @(posedge clk);
    #1;
    build_frame();
    t0    = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task wait_done(input string name);
    int n0;
    n0 = frames_done;
    for (int i = 0; i < 20000 && frames_done == n0; i++) @(posedge clk);
    check(name, frames_done != n0, 1);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 40'(k) * 40'h0100000001;
    reset = 1'b0; start = 1'b0; tx_ready = 1'b1;
    ready_toggle = 1'b0; stall_on = 1'b0; stall_cnt = 0;
    nbytes = 0; last_cyc = 0; done_cyc = 0; frames_done = 0; rd_cnt = 0; exp_addr = 0; t0 = 0;
    prev_en = 1'b0; prev_stall = 1'b0; zero_next = 1'b0;
    fork
      compare_loop();
      ready_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame with ready held high
    launch();
    wait_done("basic_frame_done");
    @(negedge clk);
    check("basic_busy_low", busy, 0);
    check("basic_last_cycle", last_cyc - t0, 5378);
    check("basic_done_cycle", done_cyc - t0, 5379);
    check("basic_busy_cycle", cyc - t0, 5380);
    check("basic_nbytes", nbytes, TOTAL);
    check("basic_hdr0", rx[0], 8'hA5);
    check("basic_hdr1", rx[1], 8'h5A);
    check("basic_w1b0", rx[7], 8'h01);
    check("basic_w1b1", rx[8], 8'h00);
    check("basic_w1b2", rx[9], 8'h00);
    check("basic_w1b3", rx[10], 8'h00);
    check("basic_w1b4", rx[11], 8'h01);

    // Byte order of word 0
    mem[0] = 40'h123456789A;
    launch();
    wait_done("order_frame_done");
    check("order_b0", rx[2], 8'h9A);
    check("order_b1", rx[3], 8'h78);
    check("order_b2", rx[4], 8'h56);
    check("order_b3", rx[5], 8'h34);
    check("order_b4", rx[6], 8'h12);

    // Toggling ready plus a long stall on byte 2 of the last word
    ready_toggle = 1'b1; stall_on = 1'b1; stall_cnt = 0;
    launch();
    wait_done("bp_frame_done");
    check("bp_nbytes", nbytes, TOTAL);
    check("bp_stall_len", stall_cnt, 100);
    ready_toggle = 1'b0; stall_on = 1'b0;
    repeat (3) @(posedge clk);

    // Start pulses while busy and in the DONE cycle are ignored
    launch();
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5379 - 51) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("sb_done_cycle", done_cyc - t0, 5379);
    check("sb_frames", frames_done, 4);
    check("sb_busy_low", busy, 0);
    repeat (10) @(negedge clk);
    check("sb_still_idle", busy, 0);
    check("sb_no_valid", tx_valid, 0);

    // Reset during word 300 byte 2, then a fresh full frame
    launch();
    repeat (2106) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_point_bytes", nbytes, 1504);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle_busy", busy, 0);
    check("rst_frames", frames_done, 4);
    launch();
    wait_done("rst_new_frame_done");
    check("rst_new_nbytes", nbytes, TOTAL);
    check("rst_new_hdr0", rx[0], 8'hA5);
    check("rst_new_w0b0", rx[2], 8'h9A);
    check("rst_new_done_cycle", done_cyc - t0, 5379);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_stream_tx.md
# sum_stream_tx

Transmit side of the beamformer output path. After the summing stage has written 768 40-bit delay-and-sum results into the sum RAM, this block reads them back in address order and sends them out as a framed, little-endian byte stream over a valid/ready interface toward the host link. It is the only reader of the sum RAM during transmission, and it signals completion so the top-level controller can move to its done state.

## Interface
Parameters:
- `DEPTH`, 768: number of sum words per frame.
- `ADDR_W`, 10: sum RAM address width.
- `DATA_W`, 40: sum word width; always 5 bytes.
- `SYNC0`, 8'hA5: first header byte.
- `SYNC1`, 8'h5A: second header byte.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse that requests one frame; sampled only in IDLE.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse when the frame is complete.
- `sum_read_addr`  out  ADDR_W  sum RAM read address.
- `sum_read_en`  out  1  sum RAM read enable.
- `sum_ram_data_out`  in  DATA_W  sum RAM read data; valid on the cycle after `sum_read_en`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte; a transfer occurs when `tx_valid & tx_ready`.
- `tx_last`  out  1  marks the final byte of the frame.

## Operation
- Frame layout: `SYNC0`, `SYNC1`, then words 0..DEPTH-1. Each word is sent LSB byte first: [7:0], [15:8], [23:16], [31:24], [39:32]. One frame is 2 + 5·DEPTH = 3842 bytes.
- States:
  - IDLE: when `start`=1, go to HDR0 and clear the address to 0.
  - HDR0: `tx_data`=`SYNC0`, `tx_valid`=1. Go to HDR1 on transfer.
  - HDR1: `tx_data`=`SYNC1`. Go to RD on transfer.
  - RD: `sum_read_en`=1 for exactly one cycle at the current address. Go to CAP.
  - CAP: load `sum_ram_data_out` into a 40-bit shift register, clear the byte index. Go to SEND.
  - SEND: `tx_valid`=1, `tx_data` = shift[7:0]. On each transfer, shift right by 8 and increment the byte index. After the transfer of byte index 4: if address = DEPTH-1, go to DONE; otherwise increment the address and go to RD.
  - DONE: `done`=1 for one cycle, `busy` still 1. Go to IDLE.
- `tx_last` is 1 only in SEND at address DEPTH-1 with byte index 4.
- Valid/ready rules:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_last` hold stable and no state advances.
  - `tx_valid` never drops without a transfer.
  - `tx_ready` is ignored while `tx_valid`=0.
- `start` is ignored outside IDLE, including the DONE cycle. It is not queued.
- `sum_read_addr` holds its value between reads. It is never driven to DEPTH or above.
- Reset (`reset`=0 on a clock edge) at any point, mid-frame included:
  - next state IDLE.
  - `busy`, `done`, `tx_valid`, `tx_last`, `sum_read_en` = 0.
  - `tx_data`=0, `sum_read_addr`=0, shift register cleared.
  - any partially sent word is abandoned; there is no resume.

## Timing
- All outputs are registered. Reset values are all zero as listed above.
- With `tx_ready` held at 1 and `start` at cycle 0:
  - HDR0 at cycle 1, HDR1 at cycle 2.
  - word k: RD at 3+7k, CAP at 4+7k, bytes on cycles 5+7k..9+7k.
  - `tx_last` at cycle 5378; `done` at cycle 5379; `busy` low from cycle 5380.
- Per-word overhead is 2 idle cycles on the stream (RD and CAP), during which `tx_valid`=0.
- Sum RAM read latency is exactly 1 cycle. Data is captured only in CAP.
- Back-pressure stretches only the HDR0, HDR1 and SEND states, cycle for cycle.

## Test plan
- Basic frame: RAM word k = k·0x0100000001 (40-bit), `tx_ready`=1, pulse `start` -> 3842 bytes.
  - Header A5 5A; word 1 bytes 01 00 00 00 01.
  - `tx_last` only on byte 3842; `done` at cycle 5379.
- Byte order: word 0 = 40'h123456789A -> bytes 9A 78 56 34 12 immediately after the header.
- Back-pressure: `tx_ready` toggles 1/0 each cycle -> identical byte sequence, data stable while stalled, no duplicated or dropped bytes.
  - Long stall of 100 cycles on byte 2 of word 767 -> `tx_last` not asserted early.
- Start while busy: pulse `start` at cycle 50 and again in the DONE cycle -> one frame only; `busy` low after DONE.
- Reset mid-frame: `reset`=0 for 1 cycle during word 300 byte 2 -> all outputs 0 next cycle, state IDLE. A new `start` then emits a full frame from the header with address 0.
- Read discipline: a monitor checks `sum_read_en` is high for exactly 768 single cycles per frame, with addresses 0..767 strictly increasing.
